// File: rtl/ac_control_unit_if.sv
// ac_control_unit_if
//   Bundles the decode/timing inputs, the DR bus, the input-device handshake
//   and the accumulator status outputs of ac_control_unit.
//
//   Handshake (valid/ready): the device drives in_valid/in_data; a character
//   is transferred on a rising clk edge where in_valid & in_ready are both
//   high. in_ready is ~fgi, so at most one character is buffered until the
//   CPU consumes it with INP.
//
//   master : timing/decode logic plus the input device (drives commands,
//            operand and character; observes AC, E, flag and skip)
//   slave  : ac_control_unit
interface ac_control_unit_if #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = 8
);
    logic                d0;
    logic                d1;
    logic                d2;
    logic                t5;
    logic                r;
    logic                p;
    logic [11:0]         ir_b;
    logic [WIDTH-1:0]    d_ac;
    logic                in_valid;
    logic [IN_WIDTH-1:0] in_data;
    logic                in_ready;
    logic                fgi;
    logic [WIDTH-1:0]    q_ac;
    logic                q_e;
    logic                skip;

    modport master (
        output d0, d1, d2, t5, r, p, ir_b, d_ac, in_valid, in_data,
        input  in_ready, fgi, q_ac, q_e, skip
    );

    modport slave (
        input  d0, d1, d2, t5, r, p, ir_b, d_ac, in_valid, in_data,
        output in_ready, fgi, q_ac, q_e, skip
    );
endinterface

// File: rtl/ac_control_unit.sv
// ac_control_unit
//   Accumulator datapath for the basic computer: AND/ADD/LDA memory
//   reference at T5, the register-reference set on AC/E, and the input port
//   (INPR buffer, FGI flag, INP and SKI).
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset
//     bus  - ac_control_unit_if.slave: d0..d2, t5, r, p, ir_b, d_ac,
//            in_valid/in_data/in_ready, fgi, q_ac, q_e, skip
//
//   All results appear on the outputs one clock after the command cycle.
//   skip is a registered one-cycle pulse.
module ac_control_unit #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    ac_control_unit_if.slave bus
);

    logic [WIDTH-1:0]    ac_q, ac_n;
    logic                e_q, e_n;
    logic                fgi_q, fgi_n;
    logic [IN_WIDTH-1:0] inpr_q, inpr_n;
    logic                skip_q, skip_n;
    logic                inp_exec;
    logic                unused_ir0;

    assign unused_ir0 = bus.ir_b[0];

    always_comb begin
        ac_n     = ac_q;
        e_n      = e_q;
        fgi_n    = fgi_q;
        inpr_n   = inpr_q;
        skip_n   = 1'b0;
        inp_exec = 1'b0;

        if (bus.t5 && bus.d0) begin
            ac_n = ac_q & bus.d_ac;
        end else if (bus.t5 && bus.d1) begin
            {e_n, ac_n} = {1'b0, ac_q} + {1'b0, bus.d_ac};
        end else if (bus.t5 && bus.d2) begin
            ac_n = bus.d_ac;
        end else if (bus.r) begin
            // Highest set bit of ir_b[11:5] wins.
            if (bus.ir_b[11]) begin
                ac_n = '0;
            end else if (bus.ir_b[10]) begin
                e_n = 1'b0;
            end else if (bus.ir_b[9]) begin
                ac_n = ~ac_q;
            end else if (bus.ir_b[8]) begin
                e_n = ~e_q;
            end else if (bus.ir_b[7]) begin
                ac_n = {e_q, ac_q[WIDTH-1:1]};
                e_n  = ac_q[0];
            end else if (bus.ir_b[6]) begin
                ac_n = {ac_q[WIDTH-2:0], e_q};
                e_n  = ac_q[WIDTH-1];
            end else if (bus.ir_b[5]) begin
                ac_n = ac_q + WIDTH'(1);
            end
            // Skip tests look at the values before this cycle's update.
            skip_n = (bus.ir_b[4] & ~ac_q[WIDTH-1])
                   | (bus.ir_b[3] &  ac_q[WIDTH-1])
                   | (bus.ir_b[2] & (ac_q == '0))
                   | (bus.ir_b[1] & ~e_q);
        end else if (bus.p) begin
            if (bus.ir_b[11]) begin
                ac_n[IN_WIDTH-1:0] = inpr_q;
                fgi_n              = 1'b0;
                inp_exec           = 1'b1;
            end
            if (bus.ir_b[9] && fgi_q) begin
                skip_n = 1'b1;
            end
        end

        // An INP in the same cycle keeps the buffer closed until the next
        // edge, so the flag clear is never overridden by a new character.
        if (bus.in_valid && !fgi_q && !inp_exec) begin
            inpr_n = bus.in_data;
            fgi_n  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ac_q   <= '0;
            e_q    <= 1'b0;
            fgi_q  <= 1'b0;
            inpr_q <= '0;
            skip_q <= 1'b0;
        end else begin
            ac_q   <= ac_n;
            e_q    <= e_n;
            fgi_q  <= fgi_n;
            inpr_q <= inpr_n;
            skip_q <= skip_n;
        end
    end

    assign bus.q_ac     = ac_q;
    assign bus.q_e      = e_q;
    assign bus.fgi      = fgi_q;
    assign bus.in_ready = ~fgi_q;
    assign bus.skip     = skip_q;

endmodule

// File: tb/tb_ac_control_unit.sv
module tb_ac_control_unit;

    localparam int    W    = 16;
    localparam int    IW   = 8;
    localparam longint MOD = 64'd1 << W;

    logic clk;
    logic rst;

    ac_control_unit_if #(.WIDTH(W), .IN_WIDTH(IW)) bus ();

    ac_control_unit #(.WIDTH(W), .IN_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model state, kept as plain integers.
    longint m_ac;
    longint m_inpr;
    bit     m_e;
    bit     m_fgi;
    bit     m_skip;

    logic [19:0] obs;
    logic [19:0] exp_v;
    assign obs = {bus.q_ac, bus.q_e, bus.fgi, bus.in_ready, bus.skip};

    function automatic logic [19:0] model_status();
        return {W'(m_ac), m_e, m_fgi, !m_fgi, m_skip};
    endfunction

    // Advance the model by one clock using the instruction rules.
    task automatic model_step(input bit rs, input bit t5, input bit d0, input bit d1,
                              input bit d2, input bit rr, input bit pp,
                              input logic [11:0] ir, input longint dac,
                              input bit iv, input longint id);
        longint ac;
        bit e, f, sk, inp;
        int sel;
        ac = m_ac; e = m_e; f = m_fgi; sk = 0; inp = 0;
        if (rs) begin
            m_ac = 0; m_e = 0; m_fgi = 0; m_inpr = 0; m_skip = 0;
            return;
        end
        if (t5 && d0) begin
            ac = m_ac & dac;
        end else if (t5 && d1) begin
            ac = (m_ac + dac) % MOD;
            e  = (m_ac + dac) >= MOD;
        end else if (t5 && d2) begin
            ac = dac;
        end else if (rr) begin
            sel = -1;
            for (int b = 11; b >= 5; b--) begin
                if (ir[b] && sel < 0) sel = b;
            end
            case (sel)
                11: ac = 0;
                10: e = 0;
                9:  ac = MOD - 1 - m_ac;
                8:  e = !m_e;
                7:  begin ac = m_ac / 2 + (m_e ? MOD / 2 : 0); e = (m_ac % 2) == 1; end
                6:  begin ac = (m_ac * 2) % MOD + (m_e ? 1 : 0); e = m_ac >= MOD / 2; end
                5:  ac = (m_ac + 1) % MOD;
                default: ;
            endcase
            sk = (ir[4] && m_ac < MOD / 2) || (ir[3] && m_ac >= MOD / 2) ||
                 (ir[2] && m_ac == 0) || (ir[1] && !m_e);
        end else if (pp) begin
            if (ir[11]) begin
                ac  = (m_ac / 256) * 256 + m_inpr;
                f   = 0;
                inp = 1;
            end
            if (ir[9] && m_fgi) sk = 1;
        end
        if (iv && !m_fgi && !inp) begin
            m_inpr = id;
            f      = 1;
        end
        m_ac = ac; m_e = e; m_fgi = f; m_skip = sk;
    endtask

    // Driver: apply one cycle of inputs, step the model, then settle past the edge.
    task automatic cycle(input bit rs, input bit t5, input bit d0, input bit d1,
                         input bit d2, input bit rr, input bit pp,
                         input logic [11:0] ir, input logic [15:0] dac,
                         input bit iv, input logic [7:0] id);
        rst          = rs;
        bus.t5       = t5;
        bus.d0       = d0;
        bus.d1       = d1;
        bus.d2       = d2;
        bus.r        = rr;
        bus.p        = pp;
        bus.ir_b     = ir;
        bus.d_ac     = dac;
        bus.in_valid = iv;
        bus.in_data  = id;
        model_step(rs, t5, d0, d1, d2, rr, pp, ir, longint'(dac), iv, longint'(id));
        @(posedge clk);
        #1;
    endtask

    task automatic lda(input logic [15:0] v);
        cycle(0, 1, 0, 0, 1, 0, 0, 12'h0, v, 0, 8'h0);
    endtask
    task automatic add(input logic [15:0] v);
        cycle(0, 1, 0, 1, 0, 0, 0, 12'h0, v, 0, 8'h0);
    endtask
    task automatic cmd_r(input logic [11:0] ir);
        cycle(0, 0, 0, 0, 0, 1, 0, ir, 16'h0, 0, 8'h0);
    endtask
    task automatic cmd_p(input logic [11:0] ir, input bit iv, input logic [7:0] id);
        cycle(0, 0, 0, 0, 0, 0, 1, ir, 16'h0, iv, id);
    endtask
    task automatic idle(input bit iv, input logic [7:0] id);
        cycle(0, 0, 0, 0, 0, 0, 0, 12'h0, 16'h0, iv, id);
    endtask

    // Status nibble below: {q_e, fgi, in_ready, skip}.
    task automatic test_reset();
        cycle(1, 0, 0, 0, 0, 0, 0, 12'h0, 16'h0, 0, 8'h0);
        cycle(1, 0, 0, 0, 0, 0, 0, 12'h0, 16'h0, 0, 8'h0);
        n_vec++;
        if (obs !== {16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL reset: got %h want %h", obs, {16'h0000, 4'b0010});
        end
    endtask

    task automatic test_load_clear_add();
        lda(16'hCCE1);
        n_vec++;
        if (obs !== {16'hCCE1, 4'b0010}) begin
            n_err++; $display("FAIL lda: got %h want %h", obs, {16'hCCE1, 4'b0010});
        end
        cmd_r(12'h800);
        n_vec++;
        if (obs !== {16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL cla: got %h want %h", obs, {16'h0000, 4'b0010});
        end
        add(16'h1DFF);
        n_vec++;
        if (obs !== {16'h1DFF, 4'b0010}) begin
            n_err++; $display("FAIL add: got %h want %h", obs, {16'h1DFF, 4'b0010});
        end
        cmd_r(12'h020);
        n_vec++;
        if (obs !== {16'h1E00, 4'b0010}) begin
            n_err++; $display("FAIL inc: got %h want %h", obs, {16'h1E00, 4'b0010});
        end
    endtask

    task automatic test_carry_rotate();
        lda(16'hFFFF);
        add(16'h0001);
        n_vec++;
        if (obs !== {16'h0000, 4'b1010}) begin
            n_err++; $display("FAIL add_carry: got %h want %h", obs, {16'h0000, 4'b1010});
        end
        cmd_r(12'h080);
        n_vec++;
        if (obs !== {16'h8000, 4'b0010}) begin
            n_err++; $display("FAIL cir: got %h want %h", obs, {16'h8000, 4'b0010});
        end
        cmd_r(12'h040);
        n_vec++;
        if (obs !== {16'h0000, 4'b1010}) begin
            n_err++; $display("FAIL cil: got %h want %h", obs, {16'h0000, 4'b1010});
        end
        cmd_r(12'h200);
        n_vec++;
        if (obs !== {16'hFFFF, 4'b1010}) begin
            n_err++; $display("FAIL cma: got %h want %h", obs, {16'hFFFF, 4'b1010});
        end
    endtask

    task automatic test_priority();
        lda(16'h1234);
        cmd_r(12'h880);
        n_vec++;
        if (obs !== {16'h0000, 4'b1010}) begin
            n_err++; $display("FAIL cla_over_cir: got %h want %h", obs, {16'h0000, 4'b1010});
        end
        lda(16'h0F0F);
        // AND at T5 outranks a simultaneous register-reference CLA.
        cycle(0, 1, 1, 0, 0, 1, 0, 12'h800, 16'h00FF, 0, 8'h0);
        n_vec++;
        if (obs !== {16'h000F, 4'b1010}) begin
            n_err++; $display("FAIL and_over_r: got %h want %h", obs, {16'h000F, 4'b1010});
        end
    endtask

    task automatic test_skip();
        cmd_r(12'h400);
        cmd_r(12'h800);
        n_vec++;
        if (obs !== {16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL cle_cla: got %h want %h", obs, {16'h0000, 4'b0010});
        end
        cmd_r(12'h014);
        n_vec++;
        if (obs !== {16'h0000, 4'b0011}) begin
            n_err++; $display("FAIL skip_spa_sza: got %h want %h", obs, {16'h0000, 4'b0011});
        end
        idle(0, 8'h0);
        n_vec++;
        if (obs !== {16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL skip_pulse_end: got %h want %h", obs, {16'h0000, 4'b0010});
        end
        cmd_r(12'h008);
        n_vec++;
        if (obs !== {16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL sna_noskip: got %h want %h", obs, {16'h0000, 4'b0010});
        end
        cmd_r(12'h002);
        n_vec++;
        if (obs !== {16'h0000, 4'b0011}) begin
            n_err++; $display("FAIL sze: got %h want %h", obs, {16'h0000, 4'b0011});
        end
    endtask

    task automatic test_input();
        idle(1, 8'hA5);
        n_vec++;
        if (obs !== {16'h0000, 4'b0100}) begin
            n_err++; $display("FAIL accept: got %h want %h", obs, {16'h0000, 4'b0100});
        end
        idle(1, 8'h77);
        cmd_p(12'h200, 0, 8'h0);
        n_vec++;
        if (obs !== {16'h0000, 4'b0101}) begin
            n_err++; $display("FAIL ski: got %h want %h", obs, {16'h0000, 4'b0101});
        end
        cmd_p(12'h800, 1, 8'h3C);
        n_vec++;
        if (obs !== {16'h00A5, 4'b0010}) begin
            n_err++; $display("FAIL inp: got %h want %h", obs, {16'h00A5, 4'b0010});
        end
        idle(1, 8'h3C);
        n_vec++;
        if (obs !== {16'h00A5, 4'b0100}) begin
            n_err++; $display("FAIL reaccept: got %h want %h", obs, {16'h00A5, 4'b0100});
        end
        lda(16'hAB00);
        cmd_p(12'h800, 0, 8'h0);
        n_vec++;
        if (obs !== {16'hAB3C, 4'b0010}) begin
            n_err++; $display("FAIL inp_upper: got %h want %h", obs, {16'hAB3C, 4'b0010});
        end
        cmd_p(12'h200, 0, 8'h0);
        n_vec++;
        if (obs !== {16'hAB3C, 4'b0010}) begin
            n_err++; $display("FAIL ski_noflag: got %h want %h", obs, {16'hAB3C, 4'b0010});
        end
    endtask

    task automatic test_reset_mid();
        lda(16'hFFFF);
        idle(1, 8'h5A);
        cycle(1, 1, 0, 1, 0, 0, 0, 12'h0, 16'h0001, 1, 8'h11);
        n_vec++;
        if (obs !== {16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL reset_mid: got %h want %h", obs, {16'h0000, 4'b0010});
        end
        lda(16'h00FF);
        cmd_p(12'h800, 0, 8'h0);
        n_vec++;
        if (obs !== {16'h0000, 4'b0010}) begin
            n_err++; $display("FAIL inpr_reset: got %h want %h", obs, {16'h0000, 4'b0010});
        end
    endtask

    task automatic test_random();
        bit t5, d0, d1, d2, rr, pp, iv, rs;
        logic [11:0] ir;
        logic [15:0] dac;
        logic [7:0]  id;
        for (int i = 0; i < 400; i++) begin
            rs  = ($urandom_range(0, 49) == 0);
            t5  = ($urandom_range(0, 2) == 0);
            d0  = ($urandom_range(0, 3) == 0);
            d1  = ($urandom_range(0, 3) == 0);
            d2  = ($urandom_range(0, 3) == 0);
            rr  = ($urandom_range(0, 2) == 0);
            pp  = ($urandom_range(0, 2) == 0);
            ir  = 12'($urandom);
            if ($urandom_range(0, 1) == 1) ir = ir & 12'h0FF;
            dac = 16'($urandom);
            iv  = ($urandom_range(0, 1) == 1);
            id  = 8'($urandom);
            cycle(rs, t5, d0, d1, d2, rr, pp, ir, dac, iv, id);
            exp_v = model_status();
            n_vec++;
            if (obs !== exp_v) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_ac = 0; m_inpr = 0; m_e = 0; m_fgi = 0; m_skip = 0;
        rst = 1'b1;
        bus.t5 = 0; bus.d0 = 0; bus.d1 = 0; bus.d2 = 0; bus.r = 0; bus.p = 0;
        bus.ir_b = '0; bus.d_ac = '0; bus.in_valid = 0; bus.in_data = '0;
        #1;
        test_reset();
        test_load_clear_add();
        test_carry_rotate();
        test_priority();
        test_skip();
        test_input();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
